// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: raster sequencer for the HDMI colorbar path.
// It walks a horizontal/vertical counter pair over the full frame and decodes
// sync and active-video from the counter position. Sync/DE/frame_start/busy are
// registered, one cycle behind the counters. pix_req/pix_x/pix_y are
// combinational, so the pixel generator sees its request one cycle before DE.
// Run/stop requests take effect only on frame boundaries, so a frame is never
// cut short except by reset.
module hdmi_timing_ctrl #(
    parameter int   H_SYNC  = 96,
    parameter int   H_BACK  = 48,
    parameter int   H_DISP  = 640,
    parameter int   H_FRONT = 16,
    parameter int   V_SYNC  = 2,
    parameter int   V_BACK  = 33,
    parameter int   V_DISP  = 480,
    parameter int   V_FRONT = 10,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1,
    parameter int   CNT_W   = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             video_hs,
    output logic             video_vs,
    output logic             video_de,
    output logic             frame_start,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_DISP);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_DISP);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic             video_hs_q;
    logic             video_vs_q;
    logic             video_de_q;
    logic             frame_start_q;
    logic             busy_q;
    logic [15:0]      frame_cnt_q;

    logic             running_s;
    logic             h_last_s;
    logic             at_last_s;
    logic [CNT_W-1:0] h_adv_s;
    logic [CNT_W-1:0] v_adv_s;
    logic             hs_a_s;
    logic             vs_a_s;
    logic             act_s;

    // Position decode: wrap points, advanced counter values, sync and active flags.
    always_comb begin
        running_s = (state_q != ST_IDLE);
        h_last_s  = (h_cnt_q == H_LAST_C);
        at_last_s = h_last_s && (v_cnt_q == V_LAST_C);
        if (h_last_s) begin
            h_adv_s = CNT_ZERO;
            if (v_cnt_q == V_LAST_C) begin
                v_adv_s = CNT_ZERO;
            end else begin
                v_adv_s = v_cnt_q + CNT_ONE;
            end
        end else begin
            h_adv_s = h_cnt_q + CNT_ONE;
            v_adv_s = v_cnt_q;
        end
        hs_a_s = running_s && (h_cnt_q < H_SYNC_C);
        vs_a_s = running_s && (v_cnt_q < V_SYNC_C);
        act_s  = running_s &&
                 (h_cnt_q >= H_START_C) && (h_cnt_q < H_END_C) &&
                 (v_cnt_q >= V_START_C) && (v_cnt_q < V_END_C);
    end

    // Next state and next counter values; stop requests only land on the last position.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = CNT_ZERO;
                v_cnt_d = CNT_ZERO;
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                h_cnt_d = h_adv_s;
                v_cnt_d = v_adv_s;
                // A stop seen on the final position ends the frame right here
                // rather than committing to a whole extra frame in STOP.
                if (en) begin
                    state_d = ST_RUN;
                end else if (at_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                h_cnt_d = h_adv_s;
                v_cnt_d = v_adv_s;
                if (en) begin
                    state_d = ST_RUN;
                end else if (at_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = CNT_ZERO;
                v_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // State and raster counter registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            h_cnt_q <= CNT_ZERO;
            v_cnt_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Registered video outputs, one cycle behind the counter position.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            video_hs_q    <= ~HS_POL;
            video_vs_q    <= ~VS_POL;
            video_de_q    <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= 16'h0000;
        end else begin
            video_hs_q    <= hs_a_s ? HS_POL : ~HS_POL;
            video_vs_q    <= vs_a_s ? VS_POL : ~VS_POL;
            video_de_q    <= act_s;
            frame_start_q <= running_s && (h_cnt_q == CNT_ZERO) && (v_cnt_q == CNT_ZERO);
            busy_q        <= running_s;
            if (running_s && at_last_s) begin
                frame_cnt_q <= frame_cnt_q + 16'h0001;
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
        end
    end

    // Pixel request leads video_de by one cycle; coordinates are zero outside active video.
    always_comb begin
        pix_req = act_s;
        if (act_s) begin
            pix_x = h_cnt_q - H_START_C;
            pix_y = v_cnt_q - V_START_C;
        end else begin
            pix_x = CNT_ZERO;
            pix_y = CNT_ZERO;
        end
    end

    assign video_hs    = video_hs_q;
    assign video_vs    = video_vs_q;
    assign video_de    = video_de_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl on a small 14x7 raster. A reference model tracks
// "frame in progress" and the linear position inside the frame (0..97); all
// expected outputs are computed from that position with plain arithmetic.
module tb_hdmi_timing_ctrl;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FR = HT * VT;
    localparam int CW = 12;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          en;
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          video_hs;
    logic          video_vs;
    logic          video_de;
    logic          frame_start;
    logic          busy;
    logic [15:0]   frame_cnt;

    hdmi_timing_ctrl #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
        .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    // reference model
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_fc   = 0;
    bit e_hs   = 1'b0;
    bit e_vs   = 1'b0;
    bit e_de   = 1'b0;
    bit e_fs   = 1'b0;
    bit e_busy = 1'b0;

    // observation helpers
    bit prev_r   = 1'b0;
    bit prev_req = 1'b0;
    int fs_last  = -1;
    int fs_prev  = -1;
    int fs_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic bit in_act(input int p);
        int h;
        int v;
        h = p % HT;
        v = p / HT;
        return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    endfunction

    // Called at a falling edge: check outputs, drive inputs, take one rising edge, update model.
    task automatic step(input logic r, input logic e);
        bit exp_req;
        exp_req = m_run && in_act(m_pos);
        chk("video_hs", video_hs, e_hs);
        chk("video_vs", video_vs, e_vs);
        chk("video_de", video_de, e_de);
        chk("frame_start", frame_start, e_fs);
        chk("busy", busy, e_busy);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("pix_req", pix_req, exp_req);
        chk("pix_x", pix_x, exp_req ? (m_pos % HT) - 4 : 0);
        chk("pix_y", pix_y, exp_req ? (m_pos / HT) - 2 : 0);
        if (prev_r) chk("req_leads_de", video_de, prev_req);
        if (frame_start === 1'b1) begin
            fs_prev = fs_last;
            fs_last = cyc;
            fs_seen++;
        end
        prev_req  = pix_req;
        prev_r    = r;
        sys_rst_n = r;
        en        = e;
        @(posedge sys_clk);
        if (!r) begin
            {e_hs, e_vs, e_de, e_fs, e_busy} = 5'b00000;
            m_run = 1'b0;
            m_pos = 0;
            m_fc  = 0;
        end else begin
            e_busy = m_run;
            e_fs   = m_run && (m_pos == 0);
            e_hs   = m_run && ((m_pos % HT) < 2);
            e_vs   = m_run && ((m_pos / HT) < 1);
            e_de   = m_run && in_act(m_pos);
            if (!m_run) begin
                if (e) m_run = 1'b1;
                m_pos = 0;
            end else begin
                if (m_pos == FR - 1) begin
                    m_fc = (m_fc + 1) % 65536;
                    if (!e) m_run = 1'b0;
                end
                m_pos = (m_pos + 1) % FR;
            end
        end
        cyc++;
        @(negedge sys_clk);
    endtask

    int n;
    int cnt;
    int fc_b;
    bit en_r;

    initial begin
        sys_rst_n = 1'b0;
        en        = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);

        // 1: reset held with en=1
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fs", frame_start, 1'b0);

        // 2: start; frame_start + syncs one edge after en is seen
        step(1'b1, 1'b1);
        chk("fs_early", frame_start, 1'b0);
        step(1'b1, 1'b1);
        chk("fs_first", frame_start, 1'b1);
        chk("hs_first", video_hs, 1'b1);
        chk("vs_first", video_vs, 1'b1);
        n = 0;
        for (int i = 0; i < 40 && video_de !== 1'b1; i++) begin
            step(1'b1, 1'b1);
            n++;
        end
        chk("de_latency", n, 32);
        cnt = 0;
        for (int i = 0; i < FR; i++) begin
            if (video_de === 1'b1) cnt++;
            step(1'b1, 1'b1);
        end
        chk("de_per_frame", cnt, 32);

        // 3: continuous running (pix_req/pix_x/pix_y checked each cycle)
        repeat (FR) step(1'b1, 1'b1);

        // 4: drop en at frame cycle 40
        for (int i = 0; i < 200 && m_pos != 40; i++) step(1'b1, 1'b1);
        chk("align40", m_pos, 40);
        fc_b = m_fc;
        fs_seen = 0;
        repeat (FR - 40) step(1'b1, 1'b0);
        chk("busy_at_last_edge", busy, 1'b1);
        step(1'b1, 1'b0);
        chk("busy_fall", busy, 1'b0);
        chk("de_idle", video_de, 1'b0);
        chk("hs_idle", video_hs, 1'b0);
        chk("vs_idle", video_vs, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        chk("fc_plus1", frame_cnt, (fc_b + 1) % 65536);
        chk("no_fs_after_stop", fs_seen, 0);

        // 5: drop at 40, raise at 60 -> no gap
        step(1'b1, 1'b1);
        for (int i = 0; i < 200 && m_pos != 40; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 200 && m_pos != 60; i++) step(1'b1, 1'b0);
        repeat (50) step(1'b1, 1'b1);
        chk("fs_gap", fs_last - fs_prev, FR);

        // random en activity
        en_r = 1'b1;
        repeat (800) begin
            if ($urandom_range(0, 99) < 4) en_r = ~en_r;
            step(1'b1, en_r);
        end

        // 6: reset during active video with frame_cnt=3
        step(1'b0, 1'b0);
        for (int i = 0; i < 600 && !(m_fc == 3 && m_run && in_act(m_pos)); i++) step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("fc3_before_rst", frame_cnt, 16'd3);
        chk("de_before_rst", video_de, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_de", video_de, 1'b0);
        chk("rst_req", pix_req, 1'b0);
        chk("rst_busy2", busy, 1'b0);
        chk("rst_fc", frame_cnt, 16'd0);
        chk("rst_hs", video_hs, 1'b0);
        chk("rst_vs", video_vs, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
